scratch_burst_master: RTL

Wishbone bus initiator that issues single or incrementing-burst read/write cycles of 104-bit words (eight 13-bit lanes) toward burst-capable slaves such as the SoC scratchpad memory. It sits between a line-oriented requester (cache fill/writeback, DMA) and the system bus. It converts one request into 1..MAX_BEATS bus beats, with a per-beat data interface and a bus-timeout abort.

---
 rtl/scratch_burst_master_if.sv | 30 +++
 rtl/scratch_burst_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_burst_master_if.sv
// Wishbone bus bundle between scratch_burst_master and a burst-capable slave.
// Signal names are from the initiator's point of view.
//   cyc_o/stb_o/we_o  : cycle, strobe, write enable
//   cti_o             : cycle type (000 classic, 010 incrementing, 111 end of burst)
//   sel_o             : eight 13-bit lane selects
//   adr_o             : beat address (16-byte aligned)
//   dat_o / dat_i     : 104-bit write / read data
//   ack_i / bok_i     : slave acknowledge / burst-ok
interface scratch_burst_master_if;
    logic         cyc_o;
    logic         stb_o;
    logic         we_o;
    logic [2:0]   cti_o;
    logic [7:0]   sel_o;
    logic [15:0]  adr_o;
    logic [103:0] dat_o;
    logic         ack_i;
    logic         bok_i;
    logic [103:0] dat_i;

    modport master (
        output cyc_o, stb_o, we_o, cti_o, sel_o, adr_o, dat_o,
        input  ack_i, bok_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, cti_o, sel_o, adr_o, dat_o,
        output ack_i, bok_i, dat_i
    );
endinterface

// File: rtl/scratch_burst_master.sv
// Wishbone initiator turning one line request into 1..MAX_BEATS beats of 104-bit data,
// using an incrementing burst when the slave accepts it and classic cycles otherwise.
// Ports:
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   req_*_i                       : request strobe, direction, address, beat count, lane selects
//   busy_o, done_o, err_o         : request in progress, completion pulse, timeout pulse
//   wr_beat_o, wr_dat_i           : index of the write beat on the bus and its data
//   rd_vld_o, rd_beat_o, rd_dat_o : registered read beat stream
//   wb_io                         : Wishbone bus (master modport)
module scratch_burst_master #(
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         req_we_i,
    input  logic [15:0]  req_adr_i,
    input  logic [2:0]   req_len_i,
    input  logic [7:0]   req_sel_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [2:0]   wr_beat_o,
    input  logic [103:0] wr_dat_i,
    output logic         rd_vld_o,
    output logic [2:0]   rd_beat_o,
    output logic [103:0] rd_dat_o,
    scratch_burst_master_if.master wb_io
);
    localparam int unsigned CntW       = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [2:0] MaxLen      = 3'(MAX_BEATS);
    localparam logic [2:0] CtiClassic  = 3'b000;
    localparam logic [2:0] CtiInc      = 3'b010;
    localparam logic [2:0] CtiEnd      = 3'b111;

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

    state_e         state_q, state_d;
    logic           cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [2:0]     cti_q, cti_d;
    logic [7:0]     sel_q, sel_d;
    logic [15:0]    adr_q, adr_d;
    logic [2:0]     len_q, len_d, beat_q, beat_d, wr_beat_q, wr_beat_d;
    logic           burst_q, burst_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic           rd_vld_q, rd_vld_d;
    logic [2:0]     rd_beat_q, rd_beat_d;
    logic [103:0]   rd_dat_q, rd_dat_d;

    logic [2:0] len_eff;
    logic [2:0] beat_nxt;
    logic       last_beat;
    logic       burst_nxt;
    logic       unused_adr;

    assign unused_adr = ^req_adr_i[3:0];

    // Requested length with 0 promoted to a single beat and oversize clamped.
    always_comb begin
        len_eff = req_len_i;
        if (req_len_i == 3'd0) begin
            len_eff = 3'd1;
        end else if (req_len_i > MaxLen) begin
            len_eff = MaxLen;
        end
    end

    assign beat_nxt  = beat_q + 3'd1;
    assign last_beat = (beat_q == len_q - 3'd1);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        cti_d     = cti_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        wr_beat_d = wr_beat_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_vld_d  = 1'b0;
        rd_beat_d = rd_beat_q;
        rd_dat_d  = rd_dat_q;
        // A slave refusing burst on the first ack drops us to classic cycles.
        burst_nxt = burst_q && !((beat_q == 3'd0) && !wb_io.bok_i);

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    len_d     = len_eff;
                    we_d      = req_we_i;
                    sel_d     = req_sel_i;
                    adr_d     = {req_adr_i[15:4], 4'h0};
                    beat_d    = 3'd0;
                    wr_beat_d = 3'd0;
                    burst_d   = (len_eff > 3'd1);
                    cti_d     = (len_eff > 3'd1) ? CtiInc : CtiClassic;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StActive;
                end
            end
            StActive: begin
                if (wb_io.ack_i) begin
                    cnt_d = '0;
                    if (!we_q) begin
                        rd_vld_d  = 1'b1;
                        rd_beat_d = beat_q;
                        rd_dat_d  = wb_io.dat_i;
                    end
                    if (last_beat) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        cti_d   = CtiClassic;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        beat_d    = beat_nxt;
                        wr_beat_d = beat_nxt;
                        adr_d     = adr_q + 16'd16;
                        burst_d   = burst_nxt;
                        if (burst_nxt) begin
                            cti_d = (beat_nxt == len_q - 3'd1) ? CtiEnd : CtiInc;
                        end else begin
                            cti_d   = CtiClassic;
                            stb_d   = 1'b0;
                            state_d = StGap;
                        end
                    end
                end else if (cnt_q == CntLast) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    cti_d   = CtiClassic;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                stb_d   = 1'b1;
                cnt_d   = '0;
                state_d = StActive;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            cti_q     <= CtiClassic;
            sel_q     <= '0;
            adr_q     <= '0;
            len_q     <= 3'd1;
            beat_q    <= '0;
            wr_beat_q <= '0;
            burst_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_beat_q <= '0;
            rd_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            cti_q     <= cti_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            wr_beat_q <= wr_beat_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_vld_q  <= rd_vld_d;
            rd_beat_q <= rd_beat_d;
            rd_dat_q  <= rd_dat_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign wr_beat_o   = wr_beat_q;
    assign rd_vld_o    = rd_vld_q;
    assign rd_beat_o   = rd_beat_q;
    assign rd_dat_o    = rd_dat_q;
    assign wb_io.cyc_o = cyc_q;
    assign wb_io.stb_o = stb_q;
    assign wb_io.we_o  = we_q;
    assign wb_io.cti_o = cti_q;
    assign wb_io.sel_o = sel_q;
    assign wb_io.adr_o = adr_q;
    assign wb_io.dat_o = wr_dat_i;
endmodule
